cvxif_dot_coproc: RTL and testbench



---
 rtl/cvxif_dot_coproc.sv | 178 +++++++++++++++++
 tb/tb_cvxif_dot_coproc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_dot_coproc.sv
// rtl/cvxif_dot_coproc.sv - CV-X-IF coprocessor for packed-int8 dot, MAC, accumulator clear and ReLU
module cvxif_dot_coproc #(
    parameter int         IdWidth = 3,
    parameter logic [6:0] Opcode  = 7'h7B
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [31:0]        issue_rs1_i,
    input  logic [31:0]        issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [31:0]        result_data_o,
    output logic               result_we_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CMT,
        ST_EXEC,
        ST_RESP
    } state_e;

    localparam logic [1:0] OP_DOT4   = 2'b00;
    localparam logic [1:0] OP_MAC4   = 2'b01;
    localparam logic [1:0] OP_ACCCLR = 2'b10;
    localparam logic [1:0] OP_RELU   = 2'b11;

    state_e             state_q, state_d;
    logic [IdWidth-1:0] id_q;
    logic [4:0]         rd_q;
    logic [1:0]         op_q;
    logic [31:0]        rs1_q, rs2_q;
    logic [31:0]        acc_q, acc_next;
    logic [31:0]        exec_data;
    logic [31:0]        dot_ext;
    logic [IdWidth-1:0] res_id_q;
    logic [4:0]         res_rd_q;
    logic [31:0]        res_data_q;

    logic [6:0]         dec_opcode;
    logic [2:0]         dec_funct3;
    logic [6:0]         dec_funct7;
    logic               instr_ok;
    logic               commit_match;
    logic               unused_instr_bits;

    assign dec_opcode        = issue_instr_i[6:0];
    assign dec_funct3        = issue_instr_i[14:12];
    assign dec_funct7        = issue_instr_i[31:25];
    assign unused_instr_bits = ^issue_instr_i[24:15];

    // Accepted funct3 values are exactly those with bit 2 clear.
    assign instr_ok = (dec_opcode == Opcode) && (dec_funct7 == 7'd0) && !dec_funct3[2];

    assign issue_ready_o     = (state_q == ST_IDLE);
    assign issue_accept_o    = issue_valid_i && issue_ready_o && instr_ok;
    assign issue_writeback_o = issue_accept_o;

    assign commit_match = commit_valid_i && (commit_id_i == id_q);

    assign result_valid_o = (state_q == ST_RESP);
    assign result_we_o    = result_valid_o;
    assign result_id_o    = res_id_q;
    assign result_rd_o    = res_rd_q;
    assign result_data_o  = res_data_q;

    // Sum of four signed byte products; range -65024..65536 needs 18 signed bits.
    function automatic logic [17:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [15:0] prod;
        logic signed [17:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            prod = $signed(a[8*i +: 8]) * $signed(b[8*i +: 8]);
            sum  = sum + $signed({{2{prod[15]}}, prod});
        end
        return sum;
    endfunction

    always_comb begin
        logic [17:0] d;
        d       = dot4(rs1_q, rs2_q);
        dot_ext = {{14{d[17]}}, d};
    end

    always_comb begin
        exec_data = '0;
        acc_next  = acc_q;
        case (op_q)
            OP_DOT4: begin
                exec_data = dot_ext;
            end
            OP_MAC4: begin
                acc_next  = acc_q + dot_ext;
                exec_data = acc_next;
            end
            OP_ACCCLR: begin
                exec_data = acc_q;
                acc_next  = '0;
            end
            OP_RELU: begin
                exec_data = ($signed(rs1_q) > 32'sd0) ? rs1_q : 32'd0;
            end
            default: begin
                exec_data = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_accept_o) begin
                    state_d = ST_WAIT_CMT;
                end
            end
            ST_WAIT_CMT: begin
                if (commit_match) begin
                    state_d = commit_kill_i ? ST_IDLE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            acc_q      <= '0;
            res_id_q   <= '0;
            res_rd_q   <= '0;
            res_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue_accept_o) begin
                id_q  <= issue_id_i;
                rd_q  <= issue_instr_i[11:7];
                op_q  <= dec_funct3[1:0];
                rs1_q <= issue_rs1_i;
                rs2_q <= issue_rs2_i;
            end
            // The accumulator only moves here, after a non-killed commit.
            if (state_q == ST_EXEC) begin
                acc_q      <= acc_next;
                res_id_q   <= id_q;
                res_rd_q   <= rd_q;
                res_data_q <= exec_data;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_dot_coproc.sv
// tb/tb_cvxif_dot_coproc.sv - self-checking bench for cvxif_dot_coproc
module tb_cvxif_dot_coproc;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [2:0]  issue_id;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic        issue_accept;
    logic        issue_writeback;
    logic        commit_valid;
    logic [2:0]  commit_id;
    logic        commit_kill;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  result_id;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic        result_we;

    int checks = 0;
    int errors = 0;

    cvxif_dot_coproc #(.IdWidth(3), .Opcode(7'h7B)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs1_i       (issue_rs1),
        .issue_rs2_i       (issue_rs2),
        .issue_accept_o    (issue_accept),
        .issue_writeback_o (issue_writeback),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id),
        .result_rd_o       (result_rd),
        .result_data_o     (result_data),
        .result_we_o       (result_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [2:0]  id;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        kill;
        logic        acc;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd0, 5'd0, f3, rd, op};
    endfunction

    function automatic vec_t v(input string name, input logic [31:0] instr, input logic [2:0] id,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic kill,
                               input logic acc, input logic [31:0] data);
        vec_t r;
        r.name = name; r.instr = instr; r.id = id; r.rs1 = rs1; r.rs2 = rs2;
        r.kill = kill; r.acc = acc; r.data = data;
        return r;
    endfunction

    // Issue at negedge, commit one cycle later, result two cycles after commit.
    task automatic run_vec(input vec_t t);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_instr = t.instr;
        issue_id    = t.id;
        issue_rs1   = t.rs1;
        issue_rs2   = t.rs2;
        #1;
        chk({t.name, ":issue_ready"}, issue_ready, 1);
        chk({t.name, ":accept"}, issue_accept, t.acc);
        chk({t.name, ":writeback"}, issue_writeback, t.acc);
        @(negedge clk);
        issue_valid = 1'b0;
        if (!t.acc) begin
            repeat (3) begin
                chk({t.name, ":rej_ready"}, issue_ready, 1);
                chk({t.name, ":rej_valid"}, result_valid, 0);
                @(negedge clk);
            end
            return;
        end
        chk({t.name, ":wait_ready"}, issue_ready, 0);
        commit_valid = 1'b1;
        commit_id    = t.id;
        commit_kill  = t.kill;
        @(negedge clk);
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        if (t.kill) begin
            chk({t.name, ":kill_ready"}, issue_ready, 1);
            chk({t.name, ":kill_valid"}, result_valid, 0);
            return;
        end
        chk({t.name, ":exec_valid"}, result_valid, 0);
        @(negedge clk);
        chk({t.name, ":valid"}, result_valid, 1);
        chk({t.name, ":we"}, result_we, 1);
        chk({t.name, ":data"}, result_data, t.data);
        chk({t.name, ":id"}, {29'd0, result_id}, {29'd0, t.id});
        chk({t.name, ":rd"}, {27'd0, result_rd}, {27'd0, t.instr[11:7]});
        @(negedge clk);
        chk({t.name, ":post_ready"}, issue_ready, 1);
        chk({t.name, ":post_valid"}, result_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dot_i, mac_i, clr_i, relu_i;
        dot_i  = mk(7'd0, 3'b000, 5'd5, 7'h7B);
        mac_i  = mk(7'd0, 3'b001, 5'd6, 7'h7B);
        clr_i  = mk(7'd0, 3'b010, 5'd7, 7'h7B);
        relu_i = mk(7'd0, 3'b011, 5'd9, 7'h7B);

        vecs.push_back(v("dot_basic", dot_i, 3'd1, 32'h01020304, 32'h01010101, 0, 1, 32'h0000000A));
        vecs.push_back(v("dot_signed", dot_i, 3'd2, 32'hFF7F8001, 32'h02020202, 0, 1, 32'hFFFFFFFE));
        vecs.push_back(v("dot_max", dot_i, 3'd7, 32'h80808080, 32'h80808080, 0, 1, 32'h00010000));
        vecs.push_back(v("clr_init", clr_i, 3'd0, 32'h0, 32'h0, 0, 1, 32'h0));
        vecs.push_back(v("mac_1", mac_i, 3'd3, 32'h01020304, 32'h01010101, 0, 1, 32'd10));
        vecs.push_back(v("mac_2", mac_i, 3'd4, 32'h01020304, 32'h01010101, 0, 1, 32'd20));
        vecs.push_back(v("clr_20", clr_i, 3'd5, 32'h0, 32'h0, 0, 1, 32'd20));
        vecs.push_back(v("mac_3", mac_i, 3'd6, 32'h01020304, 32'h01010101, 0, 1, 32'd10));
        vecs.push_back(v("mac_kill", mac_i, 3'd1, 32'h01020304, 32'h01010101, 1, 1, 32'd0));
        vecs.push_back(v("clr_10", clr_i, 3'd2, 32'h0, 32'h0, 0, 1, 32'd10));
        vecs.push_back(v("relu_pos", relu_i, 3'd3, 32'h00000005, 32'h0, 0, 1, 32'h00000005));
        vecs.push_back(v("relu_neg", relu_i, 3'd4, 32'h80000000, 32'h0, 0, 1, 32'h0));
        vecs.push_back(v("relu_zero", relu_i, 3'd5, 32'h00000000, 32'h0, 0, 1, 32'h0));
        vecs.push_back(v("rej_op33", mk(7'd0, 3'b000, 5'd5, 7'h33), 3'd6, 32'h1, 32'h1, 0, 0, 32'h0));
        vecs.push_back(v("rej_f3_100", mk(7'd0, 3'b100, 5'd5, 7'h7B), 3'd6, 32'h1, 32'h1, 0, 0, 32'h0));
        vecs.push_back(v("rej_f7", mk(7'd1, 3'b000, 5'd5, 7'h7B), 3'd6, 32'h1, 32'h1, 0, 0, 32'h0));
        vecs.push_back(v("mac_neg", mac_i, 3'd7, 32'hFF7F8001, 32'h02020202, 0, 1, 32'hFFFFFFFE));
        vecs.push_back(v("clr_neg", clr_i, 3'd0, 32'h0, 32'h0, 0, 1, 32'hFFFFFFFE));

        rst = 1'b1;
        issue_valid = 0; issue_instr = 0; issue_id = 0; issue_rs1 = 0; issue_rs2 = 0;
        commit_valid = 0; commit_id = 0; commit_kill = 0;
        result_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst:issue_ready", issue_ready, 1);
        chk("rst:accept", issue_accept, 0);
        chk("rst:writeback", issue_writeback, 0);
        chk("rst:valid", result_valid, 0);
        chk("rst:id", {29'd0, result_id}, 0);
        chk("rst:rd", {27'd0, result_rd}, 0);
        chk("rst:data", result_data, 0);
        chk("rst:we", result_we, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Same-cycle commit ignored, mismatched id ignored, then backpressure.
        @(negedge clk);
        issue_valid = 1; issue_instr = dot_i; issue_id = 3'd3;
        issue_rs1 = 32'h01020304; issue_rs2 = 32'h01010101;
        commit_valid = 1; commit_id = 3'd3; commit_kill = 0;
        result_ready = 0;
        @(negedge clk);
        issue_valid = 0;
        commit_id = 3'd4;
        repeat (3) begin
            chk("bp:wait_ready", issue_ready, 0);
            chk("bp:wait_valid", result_valid, 0);
            @(negedge clk);
        end
        commit_id = 3'd3;
        @(negedge clk);
        commit_valid = 0;
        chk("bp:exec_valid", result_valid, 0);
        @(negedge clk);
        chk("bp:valid_rise", result_valid, 1);
        chk("bp:data_rise", result_data, 32'h0000000A);
        repeat (5) begin
            @(negedge clk);
            chk("bp:hold_valid", result_valid, 1);
            chk("bp:hold_data", result_data, 32'h0000000A);
            chk("bp:hold_id", {29'd0, result_id}, 3);
            chk("bp:hold_ready", issue_ready, 0);
        end
        result_ready = 1;
        @(negedge clk);
        chk("bp:post_valid", result_valid, 0);
        chk("bp:post_ready", issue_ready, 1);

        // Reset while waiting for commit clears acc and drops the instruction.
        run_vec(v("mac_pre_rst1", mac_i, 3'd1, 32'h01020304, 32'h01010101, 0, 1, 32'd10));
        @(negedge clk);
        issue_valid = 1; issue_instr = mac_i; issue_id = 3'd2;
        @(negedge clk);
        issue_valid = 0;
        chk("rstw:in_wait", issue_ready, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstw:ready", issue_ready, 1);
        chk("rstw:valid", result_valid, 0);
        run_vec(v("clr_after_rstw", clr_i, 3'd3, 32'h0, 32'h0, 0, 1, 32'd0));

        // Reset while holding a result.
        run_vec(v("mac_pre_rst2", mac_i, 3'd4, 32'h01020304, 32'h01010101, 0, 1, 32'd10));
        result_ready = 0;
        @(negedge clk);
        issue_valid = 1; issue_instr = mac_i; issue_id = 3'd5;
        issue_rs1 = 32'h01020304; issue_rs2 = 32'h01010101;
        @(negedge clk);
        issue_valid = 0;
        commit_valid = 1; commit_id = 3'd5;
        @(negedge clk);
        commit_valid = 0;
        @(negedge clk);
        chk("rstr:valid_before", result_valid, 1);
        chk("rstr:data_before", result_data, 32'd20);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstr:valid", result_valid, 0);
        chk("rstr:ready", issue_ready, 1);
        chk("rstr:data", result_data, 0);
        result_ready = 1;
        run_vec(v("clr_after_rstr", clr_i, 3'd6, 32'h0, 32'h0, 0, 1, 32'd0));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
